// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer and its datapath.
package shift_seq_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 4;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_seq_dp.sv
// Parallel-load / bidirectional shift register. Load has priority over shift;
// with neither asserted the register holds.
module shift_seq_dp
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             dir,
    input  logic [WIDTH-1:0] data,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic             so
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q  <= '0;
            so <= 1'b0;
        end else if (load) begin
            q  <= data;
            so <= 1'b0;
        end else if (shift) begin
            if (dir == DIR_RIGHT) begin
                q  <= {si, q[WIDTH-1:1]};
                so <= q[0];
            end else begin
                q  <= {q[WIDTH-2:0], si};
                so <= q[WIDTH-1];
            end
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Job sequencer: accepts a load/shift job, runs the shift count down on the
// datapath and holds the result under a done/ack handshake.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir,
    input  logic [CNT_W-1:0] shamt,
    input  logic             si,
    input  logic             ack,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic             so
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dir_r;
    logic             load;
    logic             shift;

    // Datapath strobes decoded from the current state so that q/so update
    // on the same edge as the state transition.
    always_comb begin
        load  = (state == S_IDLE)  && start && !abort;
        shift = (state == S_SHIFT) && !abort;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            dir_r <= DIR_LEFT;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt   <= shamt;
                        dir_r <= dir;
                        busy  <= 1'b1;
                        if (shamt != '0) begin
                            state <= S_SHIFT;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    shift_seq_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .dir   (dir_r),
        .data  (data_in),
        .si    (si),
        .q     (q),
        .so    (so)
    );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: stimulus pushes expected results,
// a monitor pops and checks them whenever done rises.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] data_in;
    logic       dir;
    logic [3:0] shamt;
    logic       si;
    logic       ack;
    logic       abort;
    logic       busy;
    logic       done;
    logic [7:0] q;
    logic       so;

    typedef struct {
        string      name;
        logic [7:0] q;
        logic       so;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic done_q = 1'b0;

    shift_seq_ctrl #(
        .WIDTH(8),
        .CNT_W(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .dir     (dir),
        .shamt   (shamt),
        .si      (si),
        .ack     (ack),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .q       (q),
        .so      (so)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: result is presented on the rising edge of done
    always @(posedge clk) begin
        #2;
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_q"},    32'(q),    32'(e.q));
                check({e.name, "_so"},   32'(so),   32'(e.so));
                check({e.name, "_busy"}, 32'(busy), 32'd1);
                check({e.name, "_lat"},  32'(cyc),  32'(e.cyc));
            end
        end
        done_q = done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_job(input string name, input logic [7:0] d, input logic dr,
                          input logic [3:0] n, input logic [15:0] si_vec,
                          input logic [7:0] eq, input logic eso, input bit disturb);
        exp_t e;
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        dir     = dr;
        shamt   = n;
        e.name = name; e.q = eq; e.so = eso; e.cyc = cyc + 1 + int'(n);
        sb.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        data_in = ~d;
        dir     = ~dr;
        shamt   = 4'd7;
        for (int i = 0; i < int'(n); i++) begin
            si = si_vec[i];
            if (disturb && i == 1) begin
                start   = 1'b1;
                ack     = 1'b1;
                data_in = 8'hFF;
                shamt   = 4'd15;
            end
            @(negedge clk);
            start = 1'b0;
            ack   = 1'b0;
        end
        if (disturb) begin
            start   = 1'b1;
            data_in = 8'hFF;
            shamt   = 4'd0;
            @(negedge clk);
            start = 1'b0;
            check({name, "_done_start_q"},    32'(q),    32'(eq));
            check({name, "_done_start_done"}, 32'(done), 32'd1);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check({name, "_ack_done"}, 32'(done), 32'd0);
        check({name, "_ack_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; data_in = '0; dir = 1'b0;
        shamt = '0; si = 1'b0; ack = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_q",    32'(q),    32'd0);
        check("rst_so",   32'(so),   32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        do_job("left3",  8'b1011_0001, 1'b0, 4'd3,  16'b101,  8'b1000_1101, 1'b1, 1'b0);
        do_job("right2", 8'b1011_0001, 1'b1, 4'd2,  16'b10,   8'b1010_1100, 1'b0, 1'b0);
        do_job("zero",   8'hA5,        1'b0, 4'd0,  16'h0000, 8'hA5,        1'b0, 1'b0);
        do_job("long10", 8'h00,        1'b0, 4'd10, 16'hFFFF, 8'hFF,        1'b1, 1'b0);
        do_job("ignore", 8'h3C,        1'b0, 4'd4,  16'h0000, 8'hC0,        1'b1, 1'b1);

        // Abort after two of five shifts
        @(negedge clk);
        start = 1'b1; data_in = 8'b1011_0001; dir = 1'b0; shamt = 4'd5;
        @(negedge clk);
        start = 1'b0; si = 1'b1;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_q",    32'(q),    32'hC7);
        check("abort_so",   32'(so),   32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        check("abort_hold_q", 32'(q), 32'hC7);

        // Asynchronous reset in the middle of a shift
        start = 1'b1; data_in = 8'h5A; dir = 1'b0; shamt = 4'd6;
        @(negedge clk);
        start = 1'b0; si = 1'b1;
        @(negedge clk);
        check("pre_rst_q",    32'(q),    32'hB5);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_q",    32'(q),    32'd0);
        check("midrst_so",   32'(so),   32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        do_job("post_rst", 8'h81, 1'b1, 4'd1, 16'h0001, 8'hC0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
